// File: rtl/cam_frame_writer.sv
// cam_frame_writer: captures one OV7670 RGB565 frame per request and writes it as RGB444 into the frame buffer.
module cam_frame_writer #(
  parameter int n  = 120,
  parameter int m  = 160,
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_captura,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          done
);
  localparam logic [AW:0] NM = (AW+1)'(n * m);
  typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_FRAME, CAPTURE, FRAME_END} state_t;
  state_t        state_q, state_d;
  logic          phase_q, phase_d, req_q, busy_q, busy_d, done_q, done_d;
  logic [6:0]    byte1_q, byte1_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d, pixel;
  logic [AW:0]   cnt_q, cnt_d;
  logic          start, unused;
  assign unused = ^{px_data[6:5], px_data[0]};
  // only the bits that survive RGB565 -> RGB444 are kept from the first byte
  assign pixel = {byte1_q[6:3], byte1_q[2:0], px_data[7], px_data[4:1]};
  assign start = init_captura & ~req_q;
  assign px_wr = state_q == CAPTURE && href && phase_q && cnt_q < NM;
  assign mem_px_data = px_wr ? pixel : data_q;
  assign mem_px_addr = addr_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    byte1_d = byte1_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (start) begin
        done_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = WAIT_VS;
      end
      WAIT_VS: state_d = vsync ? WAIT_FRAME : WAIT_VS;
      WAIT_FRAME: if (!vsync) begin
        addr_d  = '0;
        cnt_d   = '0;
        phase_d = 1'b0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        phase_d = href & ~phase_q;
        byte1_d = (href && !phase_q) ? {px_data[7:4], px_data[2:0]} : byte1_q;
        if (px_wr) begin
          data_d = pixel;
          cnt_d  = cnt_q + 1'b1;
          addr_d = (cnt_q == NM - 1'b1) ? addr_q : addr_q + 1'b1;
        end
        // vsync and the last pixel on the same cycle still leave only once
        state_d = (vsync || (px_wr && cnt_q == NM - 1'b1)) ? FRAME_END : CAPTURE;
      end
      FRAME_END: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      req_q   <= 1'b0;
      byte1_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      req_q   <= init_captura;
      byte1_q <= byte1_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: randomized byte streams against a pixel-list model of a 2x3 frame capture.
module tb_cam_frame_writer;
  localparam int NM = 6;
  logic        clk = 0, rst = 0, init_captura = 0, vsync = 0, href = 0;
  logic [7:0]  px_data = 0;
  logic [14:0] mem_px_addr;
  logic [11:0] mem_px_data;
  logic        px_wr, busy, done;
  int          n_checks = 0, n_fail = 0, exp_cnt = 0;
  logic        capturing = 0;
  logic [26:0] exp_q[$], obs_q[$];
  logic [7:0]  bytes_q[$];

  cam_frame_writer #(.n(2), .m(3), .AW(15), .DW(12)) dut (
    .clk(clk), .rst(rst), .init_captura(init_captura), .vsync(vsync), .href(href),
    .px_data(px_data), .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
    .px_wr(px_wr), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(negedge clk) if (px_wr === 1'b1) obs_q.push_back({mem_px_addr, mem_px_data});

  function automatic logic [11:0] rgb(input int b1, input int b2);
    return 12'(((b1 >> 4) << 8) | ((((b1 & 7) << 1) | (b2 >> 7)) << 4) | ((b2 >> 1) & 15));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req();
    init_captura = 1;
    cyc();
    init_captura = 0;
    cyc();
    capturing = 1;
  endtask

  task automatic vs_pulse();
    href = 0;
    vsync = 1;
    repeat (2) cyc();
    vsync = 0;
    cyc();
    exp_cnt = 0;
  endtask

  task automatic rand_bytes(input int k);
    for (int i = 0; i < k; i++) bytes_q.push_back(8'($urandom));
  endtask

  task automatic send_line();
    for (int i = 0; i + 1 < bytes_q.size(); i += 2)
      if (capturing && exp_cnt < NM) begin
        exp_q.push_back({15'(exp_cnt), rgb(int'(bytes_q[i]), int'(bytes_q[i+1]))});
        exp_cnt++;
      end
    foreach (bytes_q[i]) begin
      href = 1;
      px_data = bytes_q[i];
      cyc();
    end
    bytes_q.delete();
    href = 0;
    repeat (2) cyc();
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < 50) begin
      cyc();
      k++;
    end
    capturing = 0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done timeout: got %b want 1", name, done);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy after done: got %b want 0", name, busy);
    end
  endtask

  task automatic check_writes(input string name);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write %0d: got addr %0d data %h want addr %0d data %h",
                 name, i, obs_q[i][26:12], obs_q[i][11:0], exp_q[i][26:12], exp_q[i][11:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_addr(input string name, input logic [14:0] want);
    n_checks++;
    if (mem_px_addr !== want) begin
      n_fail++;
      $display("FAIL %s final addr: got %0d want %0d", name, mem_px_addr, want);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({mem_px_addr, mem_px_data, px_wr, busy, done} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got addr %0d data %h wr %b busy %b done %b want all 0",
               mem_px_addr, mem_px_data, px_wr, busy, done);
    end
    rst = 1;
    cyc();
  endtask

  task automatic test_full_frame();
    start_req();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL full start: got busy %b done %b want 1 0", busy, done);
    end
    vs_pulse();
    repeat (2) begin
      rand_bytes(6);
      send_line();
    end
    wait_done("full");
    check_addr("full", 15'd5);
    check_writes("full");
  endtask

  task automatic test_byte_mapping();
    start_req();
    vs_pulse();
    bytes_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    rand_bytes(2);
    send_line();
    rand_bytes(6);
    send_line();
    wait_done("map");
    n_checks++;
    if (obs_q.size() < 2 || obs_q[0][11:0] !== 12'hF0F || obs_q[1][11:0] !== 12'h0F0) begin
      n_fail++;
      $display("FAIL map pixels: got %0d writes first %h second %h want F0F 0F0", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0][11:0] : 12'h0, obs_q.size() > 1 ? obs_q[1][11:0] : 12'h0);
    end
    check_writes("map");
  endtask

  task automatic test_midframe_start();
    for (int i = 0; i < 12; i++) begin
      href = 1;
      px_data = 8'($urandom);
      init_captura = (i >= 4);
      cyc();
    end
    init_captura = 0;
    href = 0;
    cyc();
    capturing = 1;
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe early: got %0d writes busy %b done %b want 0 1 0", obs_q.size(), busy, done);
    end
    vs_pulse();
    repeat (2) begin
      rand_bytes(6);
      send_line();
    end
    wait_done("midframe");
    check_writes("midframe");
  endtask

  task automatic test_overlong();
    start_req();
    vs_pulse();
    rand_bytes(16);
    send_line();
    wait_done("overlong");
    check_addr("overlong", 15'd5);
    check_writes("overlong");
  endtask

  task automatic test_short_odd();
    start_req();
    vs_pulse();
    rand_bytes(9);
    foreach (bytes_q[i]) if (i % 2 == 1) begin
      exp_q.push_back({15'(exp_cnt), rgb(int'(bytes_q[i-1]), int'(bytes_q[i]))});
      exp_cnt++;
    end
    foreach (bytes_q[i]) begin
      href = 1;
      px_data = bytes_q[i];
      cyc();
    end
    bytes_q.delete();
    href = 0;
    vsync = 1;
    wait_done("short");
    vsync = 0;
    check_addr("short", 15'd4);
    check_writes("short");
  endtask

  task automatic test_reset_capture();
    start_req();
    vs_pulse();
    rand_bytes(4);
    send_line();
    check_writes("pre-reset");
    href = 1;
    px_data = 8'($urandom);
    rst = 0;
    capturing = 0;
    #1;
    n_checks++;
    if ({mem_px_addr, mem_px_data, px_wr, busy, done} !== 30'd0) begin
      n_fail++;
      $display("FAIL async reset: got addr %0d data %h wr %b busy %b done %b want all 0",
               mem_px_addr, mem_px_data, px_wr, busy, done);
    end
    cyc();
    rst = 1;
    cyc();
    vs_pulse();
    rand_bytes(12);
    send_line();
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post-reset idle: got %0d writes busy %b done %b want 0 0 0", obs_q.size(), busy, done);
    end
    obs_q.delete();
  endtask

  initial begin
    repeat (3) cyc();
    test_reset();
    test_full_frame();
    test_byte_mapping();
    test_midframe_start();
    test_overlong();
    test_short_odd();
    test_reset_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
